decode_stage: RTL

- ID pipeline stage of the RV32I core: decodes the fetched instruction word into the control bundle consumed by EX.
- Drives the EX-side ALU select (`ADD, `SUB, `AND, `OR, `XOR, `LeftShift, `RightShiftLogic, `RightShiftMath, `SLTU, `SLT, `LUI from control.vh), operand selects, immediate, register indices and memory/branch controls.
- One registered pipeline slot with valid/ready handshake, stall and flush.

---
 rtl/decode_stage_pkg.sv | 64 ++++++
 rtl/decode_stage_imm_gen.sv | 26 ++
 rtl/decode_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode constants and the ID->EX control bundle.
// ALU select values match control.vh.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0]  alu_sel;
    logic [1:0]  op1_sel;
    logic [1:0]  op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic        branch;
    logic [2:0]  br_funct3;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction for the I/S/B/U/J formats,
// sign-extended from instruction bit 31.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S: imm = {{21{instr[31]}}, instr[30:25],
                    instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes the fetched word into the EX
// control bundle held in a single valid/ready slot.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_sel,
  output logic [1:0]      op1_sel,
  output logic [1:0]      op2_sel,
  output logic [31:0]     imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic [2:0]      mem_funct3,
  output logic            branch,
  output logic [2:0]      br_funct3,
  output logic            jump,
  output logic            jalr,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  imm_fmt_e    fmt;
  logic [31:0] imm_w;
  logic        ill;
  id_ex_t      d;
  id_ex_t      q;
  logic        valid_q;
  logic [XLEN-1:0] pc_q;
  logic        accept;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  always_comb begin
    fmt = IMM_I;
    unique case (1'b1)
      (opc == OPC_STORE):  fmt = IMM_S;
      (opc == OPC_BRANCH): fmt = IMM_B;
      (opc == OPC_LUI),
      (opc == OPC_AUIPC):  fmt = IMM_U;
      (opc == OPC_JAL):    fmt = IMM_J;
      default:             fmt = IMM_I;
    endcase
  end

  decode_stage_imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm_w)
  );

  always_comb begin
    d         = '0;
    ill       = 1'b0;
    d.alu_sel = ALU_ADD;
    d.rs1     = in_instr[19:15];
    d.rs2     = in_instr[24:20];
    d.rd      = in_instr[11:7];
    d.imm     = imm_w;
    unique case (1'b1)
      (opc == OPC_OP): begin
        d.reg_we = 1'b1;
        unique case (f3)
          3'd0: d.alu_sel = f7[5] ? ALU_SUB : ALU_ADD;
          3'd1: d.alu_sel = ALU_SLL;
          3'd2: d.alu_sel = ALU_SLT;
          3'd3: d.alu_sel = ALU_SLTU;
          3'd4: d.alu_sel = ALU_XOR;
          3'd5: d.alu_sel = f7[5] ? ALU_SRA : ALU_SRL;
          3'd6: d.alu_sel = ALU_OR;
          default: d.alu_sel = ALU_AND;
        endcase
      end
      (opc == OPC_OP_IMM): begin
        d.reg_we  = 1'b1;
        d.op2_sel = OP2_IMM;
        unique case (f3)
          3'd0: d.alu_sel = ALU_ADD;
          3'd1: begin
            d.alu_sel = ALU_SLL;
            ill = (f7 != 7'h00);
          end
          3'd2: d.alu_sel = ALU_SLT;
          3'd3: d.alu_sel = ALU_SLTU;
          3'd4: d.alu_sel = ALU_XOR;
          3'd5: begin
            d.alu_sel = f7[5] ? ALU_SRA : ALU_SRL;
            ill = (f7 != 7'h00) && (f7 != 7'h20);
          end
          3'd6: d.alu_sel = ALU_OR;
          default: d.alu_sel = ALU_AND;
        endcase
      end
      (opc == OPC_LUI): begin
        d.alu_sel = ALU_LUI;
        d.op1_sel = OP1_ZERO;
        d.op2_sel = OP2_IMM;
        d.reg_we  = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        d.op1_sel = OP1_PC;
        d.op2_sel = OP2_IMM;
        d.reg_we  = 1'b1;
      end
      (opc == OPC_JAL),
      (opc == OPC_JALR): begin
        d.op1_sel = OP1_PC;
        d.op2_sel = OP2_FOUR;
        d.jump    = 1'b1;
        d.jalr    = (opc == OPC_JALR);
        d.reg_we  = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        d.branch    = 1'b1;
        d.br_funct3 = f3;
        unique case (f3)
          3'd0, 3'd1: d.alu_sel = ALU_SUB;
          3'd4, 3'd5: d.alu_sel = ALU_SLT;
          3'd6, 3'd7: d.alu_sel = ALU_SLTU;
          default:    ill = 1'b1;
        endcase
      end
      (opc == OPC_LOAD): begin
        d.op2_sel    = OP2_IMM;
        d.mem_re     = 1'b1;
        d.reg_we     = 1'b1;
        d.mem_funct3 = f3;
        ill = (f3 == 3'd3) || (f3 > 3'd5);
      end
      (opc == OPC_STORE): begin
        d.op2_sel    = OP2_IMM;
        d.mem_we     = 1'b1;
        d.mem_funct3 = f3;
        ill = (f3 > 3'd2);
      end
      (opc == OPC_FENCE),
      (opc == OPC_SYSTEM): begin
      end
      default: ill = 1'b1;
    endcase
    // An illegal word keeps its indices/imm but does nothing.
    if (ill) begin
      d.alu_sel    = ALU_ADD;
      d.op1_sel    = OP1_RS1;
      d.op2_sel    = OP2_RS2;
      d.reg_we     = 1'b0;
      d.mem_re     = 1'b0;
      d.mem_we     = 1'b0;
      d.mem_funct3 = '0;
      d.branch     = 1'b0;
      d.br_funct3  = '0;
      d.jump       = 1'b0;
      d.jalr       = 1'b0;
    end
    if (d.rd == 5'd0) d.reg_we = 1'b0;
    d.illegal = ill;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      q           <= '0;
      q.alu_sel   <= ALU_ADD;
      pc_q        <= RESET_PC[XLEN-1:0];
    end else if (flush) begin
      valid_q     <= 1'b0;
      q.reg_we    <= 1'b0;
      q.mem_re    <= 1'b0;
      q.mem_we    <= 1'b0;
      q.branch    <= 1'b0;
      q.jump      <= 1'b0;
      q.jalr      <= 1'b0;
      q.illegal   <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      q           <= d;
      pc_q        <= in_pc;
    end else if (out_ready) begin
      valid_q     <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign alu_sel    = q.alu_sel;
  assign op1_sel    = q.op1_sel;
  assign op2_sel    = q.op2_sel;
  assign imm        = q.imm;
  assign rs1        = q.rs1;
  assign rs2        = q.rs2;
  assign rd         = q.rd;
  assign mem_funct3 = q.mem_funct3;
  assign br_funct3  = q.br_funct3;
  assign reg_we     = q.reg_we  && valid_q;
  assign mem_re     = q.mem_re  && valid_q;
  assign mem_we     = q.mem_we  && valid_q;
  assign branch     = q.branch  && valid_q;
  assign jump       = q.jump    && valid_q;
  assign jalr       = q.jalr    && valid_q;
  assign illegal    = q.illegal && valid_q;

endmodule
